// File: rtl/tdm_demux.sv
// tdm_demux: recovers a frame-synchronised serial TDM stream into NCH parallel W-bit words.
// Optional build macro PARITY_EN appends one even-parity slot to every frame and validates it.
module tdm_demux #(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_i,
  input  logic             din,
  output logic [NCH*W-1:0] out_data,
  output logic             out_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int DL = NCH * W;
`ifdef PARITY_EN
  localparam int FL = DL + 1;
`else
  localparam int FL = DL;
`endif
  localparam int SW = $clog2(FL);
  localparam logic [SW-1:0] LAST_SLOT = SW'(FL - 1);
  localparam logic [SW-1:0] ONE_SLOT  = SW'(1);

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t         r_state;
  logic [SW-1:0]  r_slot;
  logic [DL-1:0]  r_shadow;
  logic [SW-1:0]  w_slot_in;
  logic [DL-1:0]  w_shadow_nxt;

  // Slots past the data region (the parity slot) leave the shadow untouched.
  function automatic logic [DL-1:0] put_bit(input logic [DL-1:0] sh,
                                            input logic [SW-1:0] slot,
                                            input logic          b);
    logic [DL-1:0] res;
    int            s;
    int            idx;
    res = sh;
    s   = int'(slot);
    if (s < DL) begin
      idx      = (s / W) * W + (W - 1 - (s % W));
      res[idx] = b;
    end else begin
      res = sh;
    end
    return res;
  endfunction

`ifdef PARITY_EN
  function automatic logic even_parity(input logic [DL-1:0] d);
    return ^d;
  endfunction
`endif

  // A sync pulse always restarts the frame, so its bit lands in slot 0.
  always_comb begin
    w_slot_in = r_slot;
    if ((r_state == IDLE) || sync_i) begin
      w_slot_in = '0;
    end else begin
      w_slot_in = r_slot;
    end
    w_shadow_nxt = put_bit(r_shadow, w_slot_in, din);
  end

  assign busy = (r_state == RECV);

  // Frame receiver: slot sequencing, shadow capture and atomic publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_slot    <= '0;
      r_shadow  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (sync_i) begin
            r_shadow <= w_shadow_nxt;
            r_slot   <= ONE_SLOT;
            r_state  <= RECV;
          end else begin
            r_slot <= '0;
          end
        end
        RECV: begin
          if (sync_i) begin
            frame_err <= 1'b1;
            r_shadow  <= w_shadow_nxt;
            r_slot    <= ONE_SLOT;
          end else if (r_slot == LAST_SLOT) begin
            r_shadow <= w_shadow_nxt;
            r_slot   <= '0;
            r_state  <= IDLE;
`ifdef PARITY_EN
            if (even_parity(r_shadow) == din) begin
              out_data  <= r_shadow;
              out_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
`else
            out_data  <= w_shadow_nxt;
            out_valid <= 1'b1;
`endif
          end else begin
            r_shadow <= w_shadow_nxt;
            r_slot   <= r_slot + ONE_SLOT;
          end
        end
        default: begin
          r_state <= IDLE;
          r_slot  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed scenarios plus randomized frames against a frame-level model.
module tb_tdm_demux;

  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int DL  = NCH * W;
`ifdef PARITY_EN
  localparam int FL = DL + 1;
`else
  localparam int FL = DL;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sync_i = 1'b0;
  logic          din = 1'b0;
  logic [DL-1:0] out_data;
  logic          out_valid;
  logic          frame_err;
  logic          busy;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DL-1:0] exp_data = '0;
  int            vc, va, ec, ea;
  logic          bl;

  tdm_demux #(.NCH(NCH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .sync_i(sync_i), .din(din),
    .out_data(out_data), .out_valid(out_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic clk_in(input logic s, input logic d);
    @(negedge clk);
    sync_i = s;
    din    = d;
    @(posedge clk);
    #1;
  endtask

  // Serialises a frame (channel 0 first, MSB first, optional parity) and records pulses by slot.
  task automatic send(input logic [DL-1:0] words, input int nbits, input logic bad_par,
                      output int v_cnt, output int v_at, output int e_cnt, output int e_at,
                      output logic b_last);
    logic q[$];
    logic par;
    par = 1'b0;
    v_cnt = 0; v_at = -1; e_cnt = 0; e_at = -1;
    for (int c = 0; c < NCH; c++) begin
      logic [W-1:0] wd;
      wd = words[c*W +: W];
      for (int b = W - 1; b >= 0; b--) begin
        q.push_back(wd[b]);
        par = par ^ wd[b];
      end
    end
    par = par ^ bad_par;
`ifdef PARITY_EN
    q.push_back(par);
`endif
    for (int i = 0; i < nbits; i++) begin
      clk_in(i == 0, q[i]);
      if (out_valid === 1'b1) begin v_cnt++; v_at = i; end
      if (frame_err === 1'b1) begin e_cnt++; e_at = i; end
    end
    b_last = busy;
  endtask

  task automatic idle(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      clk_in(1'b0, 1'($urandom));
      if (out_valid !== 1'b0 || frame_err !== 1'b0) pulses++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      clk_in(1'($urandom), 1'($urandom));
      n_checks++;
      if ({out_data, out_valid, frame_err, busy} !== '0) begin
        n_errors++;
        $display("FAIL reset: data=%h valid=%b err=%b busy=%b, required all 0", out_data, out_valid, frame_err, busy);
      end
    end
    @(negedge clk);
    rst_n = 1'b1; sync_i = 1'b0;
    exp_data = '0;
  endtask

  task automatic test_single;
    send(32'h00FF3CA5, FL, 1'b0, vc, va, ec, ea, bl);
    exp_data = 32'h00FF3CA5;
    n_checks++; if (vc !== 1 || va !== FL - 1) begin n_errors++; $display("FAIL single_valid: count=%0d slot=%0d, required 1 at %0d", vc, va, FL - 1); end
    n_checks++; if (out_data !== exp_data) begin n_errors++; $display("FAIL single_data: %h, required %h", out_data, exp_data); end
    n_checks++; if (ec !== 0 || bl !== 1'b0) begin n_errors++; $display("FAIL single_err_busy: err=%0d busy=%b, required 0/0", ec, bl); end
    clk_in(1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL single_pulse_width: valid=%b one cycle later, required 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    send(32'h44332211, FL, 1'b0, vc, va, ec, ea, bl);
    n_checks++; if (vc !== 1 || va !== FL - 1 || ec !== 0) begin n_errors++; $display("FAIL b2b_first: valid=%0d@%0d err=%0d", vc, va, ec); end
    n_checks++; if (out_data !== 32'h44332211) begin n_errors++; $display("FAIL b2b_data1: %h, required 44332211", out_data); end
    send(32'h88776655, FL, 1'b0, vc, va, ec, ea, bl);
    n_checks++; if (vc !== 1 || va !== FL - 1 || ec !== 0) begin n_errors++; $display("FAIL b2b_second: valid=%0d@%0d err=%0d", vc, va, ec); end
    n_checks++; if (out_data !== 32'h88776655) begin n_errors++; $display("FAIL b2b_data2: %h, required 88776655", out_data); end
    exp_data = 32'h88776655;
  endtask

  task automatic test_sync_abort;
    send(32'hDEADBEEF, 10, 1'b0, vc, va, ec, ea, bl);
    n_checks++; if (vc !== 0 || ec !== 0 || bl !== 1'b1) begin n_errors++; $display("FAIL abort_partial: valid=%0d err=%0d busy=%b, required 0/0/1", vc, ec, bl); end
    n_checks++; if (out_data !== exp_data) begin n_errors++; $display("FAIL abort_hold: %h, required %h", out_data, exp_data); end
    send(32'h04030201, FL, 1'b0, vc, va, ec, ea, bl);
    exp_data = 32'h04030201;
    n_checks++; if (ec !== 1 || ea !== 0) begin n_errors++; $display("FAIL abort_err: count=%0d slot=%0d, required 1 at 0", ec, ea); end
    n_checks++; if (vc !== 1 || out_data !== exp_data) begin n_errors++; $display("FAIL abort_recover: valid=%0d data=%h, required 1/%h", vc, out_data, exp_data); end
  endtask

  task automatic test_reset_midframe;
    send(32'h12345678, 20, 1'b0, vc, va, ec, ea, bl);
    n_checks++; if (vc !== 0 || bl !== 1'b1) begin n_errors++; $display("FAIL midrst_partial: valid=%0d busy=%b, required 0/1", vc, bl); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_data, out_valid, frame_err, busy} !== '0) begin
      n_errors++;
      $display("FAIL midrst_async: data=%h valid=%b err=%b busy=%b, required all 0", out_data, out_valid, frame_err, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(32'h55AAF00F, FL, 1'b0, vc, va, ec, ea, bl);
    exp_data = 32'h55AAF00F;
    n_checks++; if (vc !== 1 || ec !== 0 || out_data !== exp_data) begin n_errors++; $display("FAIL midrst_clean: valid=%0d err=%0d data=%h, required 1/0/%h", vc, ec, out_data, exp_data); end
  endtask

`ifdef PARITY_EN
  task automatic test_parity;
    send(32'h00FF3CA5, FL, 1'b0, vc, va, ec, ea, bl);
    n_checks++; if (vc !== 1 || va !== DL || ec !== 0) begin n_errors++; $display("FAIL parity_good: valid=%0d@%0d err=%0d, required 1@%0d/0", vc, va, ec, DL); end
    send(32'h12345678, FL, 1'b0, vc, va, ec, ea, bl);
    exp_data = 32'h12345678;
    send(32'h00FF3CA5, FL, 1'b1, vc, va, ec, ea, bl);
    n_checks++; if (vc !== 0 || ec !== 1 || ea !== DL) begin n_errors++; $display("FAIL parity_bad: valid=%0d err=%0d@%0d, required 0/1@%0d", vc, ec, ea, DL); end
    n_checks++; if (out_data !== exp_data) begin n_errors++; $display("FAIL parity_hold: %h, required %h", out_data, exp_data); end
  endtask
`endif

  // Frame-level model: a frame publishes only when complete (and parity-clean); a truncated frame
  // is reported by the sync that starts the next one.
  task automatic test_random;
    logic          partial;
    logic          abort;
    logic          bad;
    logic [DL-1:0] words;
    int            nbits, exp_err, pulses;
    partial = 1'b0;
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < DL; k++) words[k] = 1'($urandom);
      abort = ($urandom_range(3, 0) == 0);
      bad   = 1'b0;
`ifdef PARITY_EN
      bad = ($urandom_range(2, 0) == 0);
`endif
      nbits = abort ? $urandom_range(FL - 1, 1) : FL;
      send(words, nbits, bad, vc, va, ec, ea, bl);
      exp_err = (partial ? 1 : 0) + ((bad && !abort) ? 1 : 0);
      if (!abort && !bad) exp_data = words;
      n_checks++; if (vc !== ((abort || bad) ? 0 : 1)) begin n_errors++; $display("FAIL rand_valid[%0d]: count=%0d abort=%b bad=%b", it, vc, abort, bad); end
      n_checks++; if (ec !== exp_err) begin n_errors++; $display("FAIL rand_err[%0d]: count=%0d, required %0d", it, ec, exp_err); end
      n_checks++; if (out_data !== exp_data) begin n_errors++; $display("FAIL rand_data[%0d]: %h, required %h", it, out_data, exp_data); end
      n_checks++; if (bl !== abort) begin n_errors++; $display("FAIL rand_busy[%0d]: %b, required %b", it, bl, abort); end
      partial = abort;
      if (!abort) begin
        idle($urandom_range(3, 0), pulses);
        n_checks++; if (pulses !== 0) begin n_errors++; $display("FAIL rand_idle[%0d]: %0d pulses, required 0", it, pulses); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_sync_abort();
    test_reset_midframe();
`ifdef PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receive end of the team's serial TDM multiplexer, whose select-driven mux interleaves channel bits onto one line. It recovers a frame-synchronised serial bitstream into NCH parallel channel words. A slot counter steers each received bit to its channel and bit position. Complete frames are published atomically with a one-cycle valid strobe.

## Interface
- NCH, 4, number of channels per frame (≥2)
- W, 8, bits per channel word (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- sync_i  input  1  frame start; marks the cycle carrying the first bit of a frame
- din  input  1  serial data bit, sampled every clk edge
- out_data  output  NCH*W  last good frame; channel k at bits [k*W+W-1 : k*W]
- out_valid  output  1  one-cycle pulse when out_data is updated
- frame_err  output  1  one-cycle pulse on an aborted or corrupt frame
- busy  output  1  high while a frame is being received

## Operation
- Frame format: NCH*W data bits, channel 0 first, each word MSB first; with PARITY_EN, one extra parity bit follows.
- Slot s maps to channel s/W, bit W-1-(s mod W).
- The slot counter is ceil(log2(frame length)) bits wide and never wraps; it resets to 0 at end of frame.
- States:
  - IDLE: din is ignored. sync_i=1 captures din as slot 0 and moves to RECV with slot=1.
  - RECV: every cycle captures din into the shadow register at the slot position and increments slot.
- End of frame: on the cycle the last slot is sampled, the shadow register is copied to out_data, out_valid pulses, and the block returns to IDLE.
- sync_i=1 in RECV at any slot other than last+1:
  - frame_err pulses; out_data is unchanged.
  - The current bit becomes slot 0 of a new frame and the block stays in RECV.
- sync_i=1 on the cycle after the last slot is a normal back-to-back frame start, not an error.
- out_data holds the last good frame indefinitely. The shadow register is never visible on the outputs.
- busy = (state == RECV).

## Timing
- Reset (async assert, sync release): out_data=0, out_valid=0, frame_err=0, busy=0, state=IDLE, slot=0, shadow=0.
- Take the sync cycle as cycle 0. The last data bit is sampled at edge L-1, where L=NCH*W (L=NCH*W+1 with PARITY_EN). out_data and out_valid change at that same edge, so they are visible in cycle L.
- Latency from the last bit to out_valid is 0 extra cycles (registered at the sampling edge).
- Back-to-back frames: one out_valid per frame, no idle cycle required.
- frame_err is registered at the edge where the offending sync_i is sampled.
- Reset asserted mid-frame: the partial frame is discarded and all outputs go to reset values immediately.

## Configuration
- PARITY_EN defined:
  - One even-parity bit follows the data slots (XOR of all data bits and the parity bit must be 0).
  - On mismatch, out_valid stays 0, frame_err pulses at the parity edge, and out_data is unchanged.
- PARITY_EN undefined: no parity slot exists and frame length is NCH*W.

## Test plan
- Reset check: hold rst_n=0 with random din/sync_i -> out_data=0, out_valid=0, frame_err=0, busy=0 throughout.
- Single frame (NCH=4, W=8, channels A5,3C,FF,00 sent ch0 first, MSB first) -> at cycle 32 out_data=32'h00FF3CA5, out_valid high for exactly 1 cycle, busy falls.
- Two back-to-back frames (11,22,33,44 then 55,66,77,88) -> out_valid at cycles 32 and 64; out_data=32'h44332211 then 32'h88776655.
- Sync reasserted at slot 10 of a frame, then a full frame 01,02,03,04 -> frame_err pulse at slot 10; single out_valid with out_data=32'h04030201; previous out_data held until then.
- rst_n pulsed low at slot 20 of a frame, then a clean frame 0F,F0,AA,55 -> no out_valid for the aborted frame; out_data=32'h55AAF00F afterwards.
- PARITY_EN: frame A5,3C,FF,00 with correct parity bit (0) -> out_valid at cycle 33. Same frame with parity bit 1 -> frame_err pulse, no out_valid, out_data unchanged.
